mem_io_responder: RTL

- Byte-wide memory/IO responder on the far end of the memory controller's RAM bus (rw_select / addr_in / ram_store_data / ram_load_data).
- Serves RAM reads and writes with one-cycle read latency.
- Decodes the IO region (addr_in[17:16]==2'b11) into a TX FIFO, an RX holding register and a program-finish flag.
- Drives io_buffer_full back to the controller, which gates IO stores on it.

---
 rtl/mem_io_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped TX FIFO, RX holding register and finish flag
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rw_select,
  input  logic [17:0] addr_in,
  input  logic [7:0]  ram_store_data,
  output logic [7:0]  ram_load_data,
  output logic        io_buffer_full,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        program_finish,
  output logic        io_overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  logic [7:0] mem [2**RAM_ADDR_WIDTH];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] load_q, load_d, rx_data_q, rx_data_d;
  logic rx_full_q, rx_full_d, finish_q, finish_d, ovf_q, ovf_d;
  logic is_io, io_tx, io_fin, ram_we, ram_rd, push_req, push, pop, rx_rd, rx_latch;
  logic [RAM_ADDR_WIDTH-1:0] idx;
  // Address decode, FIFO/RX bookkeeping and next-state for every register
  always_comb begin
    idx = addr_in[RAM_ADDR_WIDTH-1:0];
    is_io = addr_in[17:16] == 2'b11;
    io_tx = addr_in == 18'h30000;
    io_fin = addr_in == 18'h30004;
    ram_we = rst_in & rdy_in & rw_select & !is_io;
    ram_rd = rdy_in & !rw_select & !is_io;
    pop = rdy_in & io_tx_ready & (cnt_q != '0);
    push_req = rdy_in & rw_select & io_tx;
    push = push_req & ((cnt_q != CW'(TX_DEPTH)) | pop);
    rx_rd = rdy_in & !rw_select & io_tx;
    rx_latch = rdy_in & io_rx_valid & (!rx_full_q | rx_rd);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ovf_d = ovf_q | (push_req & !push);
    finish_d = finish_q | (rdy_in & rw_select & io_fin);
    rx_data_d = rx_latch ? io_rx_data : rx_data_q;
    rx_full_d = rx_latch | (rx_full_q & !rx_rd);
    load_d = (!rdy_in || rw_select) ? load_q : (rx_rd && rx_full_q) ? rx_data_q : 8'h00;
  end
  // Byte RAM write port; contents deliberately survive reset
  always_ff @(posedge clk_in) begin
    if (ram_we) mem[idx] <= ram_store_data;
  end
  // TX FIFO storage; validity is tracked by the pointers and count alone
  always_ff @(posedge clk_in) begin
    if (push) tx_mem[wr_ptr_q] <= ram_store_data;
  end
  // Control registers; RAM reads bypass load_d so the array read stays registered
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      load_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      rx_data_q <= '0;
      rx_full_q <= 1'b0;
      finish_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      load_q <= ram_rd ? mem[idx] : load_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      rx_data_q <= rx_data_d;
      rx_full_q <= rx_full_d;
      finish_q <= finish_d;
      ovf_q <= ovf_d;
    end
  end
  assign ram_load_data = load_q;
  assign io_buffer_full = cnt_q >= CW'(TX_DEPTH - 2);
  assign io_tx_data = tx_mem[rd_ptr_q];
  assign io_tx_valid = cnt_q != '0;
  assign io_rx_ready = !rx_full_q;
  assign program_finish = finish_q;
  assign io_overflow = ovf_q;
endmodule
